// File: rtl/msg_dispatch_controller.sv
// msg_dispatch_controller
// Sequences one received message at a time once the header demux reports
// MessageComplete: validates the latched header, starts the matching handler,
// waits for it (bounded by a timeout), then requests an ACK/NAK reply.
// RxHold keeps the receive path off the data RAM while a message is in flight.
module msg_dispatch_controller #(
  parameter int          NUM_HANDLERS = 4,
  parameter logic [15:0] ID_BASE      = 16'h0100,
  parameter logic [15:0] SYNC_WORD    = 16'h1234,
  parameter logic [15:0] MAX_BYTES    = 16'd64,
  parameter logic [15:0] TIMEOUT      = 16'd1000
) (
  input  logic                    Clock,
  input  logic                    Clear,
  input  logic [15:0]             SyncWord,
  input  logic [15:0]             MessageID,
  input  logic [15:0]             ByteCount,
  input  logic [15:0]             SequenceNumber,
  input  logic                    MessageComplete,
  output logic                    RxHold,
  output logic [NUM_HANDLERS-1:0] HandlerStart,
  input  logic [NUM_HANDLERS-1:0] HandlerDone,
  output logic [15:0]             DataLength,
  output logic                    ReplyRequest,
  output logic [1:0]              ReplyCode,
  output logic [15:0]             ReplyMsgID,
  output logic [15:0]             ReplySeq,
  input  logic                    ReplyBusy,
  output logic [15:0]             MsgCount,
  output logic [15:0]             ErrorCount,
  output logic                    SeqGap,
  output logic                    Overrun
);

  localparam int          IdxW          = (NUM_HANDLERS > 1) ? $clog2(NUM_HANDLERS) : 1;
  localparam logic [15:0] NumHandlers16 = 16'(NUM_HANDLERS);
  localparam logic [15:0] TimeoutLast   = TIMEOUT - 16'd1;
  localparam logic [15:0] HeaderBytes   = 16'd8;
  localparam logic [15:0] CountMax      = 16'hFFFF;

  localparam logic [1:0] CODE_ACK     = 2'd0;
  localparam logic [1:0] CODE_BADLEN  = 2'd1;
  localparam logic [1:0] CODE_BADID   = 2'd2;
  localparam logic [1:0] CODE_TIMEOUT = 2'd3;  // also used for a bad sync word

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CHECK    = 3'd1,
    DISPATCH = 3'd2,
    WAITDONE = 3'd3,
    REPLY    = 3'd4
  } dispatchState_t;

  // Saturating 16-bit increment for the message/error counters.
  function automatic logic [15:0] satInc(input logic [15:0] value);
    logic [15:0] result;
    if (value == CountMax) begin
      result = value;
    end else begin
      result = value + 16'd1;
    end
    return result;
  endfunction

  // One-hot decode of a handler index; out-of-range indices decode to zero.
  function automatic logic [NUM_HANDLERS-1:0] oneHot(input logic [IdxW-1:0] idx);
    logic [NUM_HANDLERS-1:0] vec;
    for (int i = 0; i < NUM_HANDLERS; i++) begin
      vec[i] = (idx == IdxW'(i));
    end
    return vec;
  endfunction

  dispatchState_t          state_r;
  logic [15:0]             msgId_r;
  logic [15:0]             byteCount_r;
  logic [15:0]             seq_r;
  logic [15:0]             sync_r;
  logic [15:0]             expectedSeq_r;
  logic                    firstSeen_r;
  logic [15:0]             timer_r;
  logic [IdxW-1:0]         handlerIdx_r;
  logic                    rxHold_r;
  logic [NUM_HANDLERS-1:0] handlerStart_r;
  logic [15:0]             dataLength_r;
  logic                    replyRequest_r;
  logic [1:0]              replyCode_r;
  logic [15:0]             replyMsgId_r;
  logic [15:0]             replySeq_r;
  logic [15:0]             msgCount_r;
  logic [15:0]             errorCount_r;
  logic                    seqGap_r;
  logic                    overrun_r;

  logic [15:0]             idOffset_s;
  logic                    checkFail_s;
  logic [1:0]              checkCode_s;
  logic                    doneHit_s;

  // Header validation on the latched fields, in priority order: sync, length, ID.
  // The ID offset is unsigned, so IDs below ID_BASE wrap high and fail too.
  always_comb begin
    idOffset_s  = msgId_r - ID_BASE;
    checkFail_s = 1'b1;
    checkCode_s = CODE_ACK;
    if (sync_r != SYNC_WORD) begin
      checkCode_s = CODE_TIMEOUT;
    end else if ((byteCount_r < HeaderBytes) || (byteCount_r > MAX_BYTES)) begin
      checkCode_s = CODE_BADLEN;
    end else if (idOffset_s >= NumHandlers16) begin
      checkCode_s = CODE_BADID;
    end else begin
      checkFail_s = 1'b0;
    end
  end

  // Only the done bit of the handler that was started is honoured.
  always_comb begin
    doneHit_s = |(HandlerDone & oneHot(handlerIdx_r));
  end

  // Message sequencer: capture, check, dispatch, wait, reply; all outputs registered.
  always_ff @(posedge Clock or posedge Clear) begin
    if (Clear) begin
      state_r        <= IDLE;
      msgId_r        <= 16'h0000;
      byteCount_r    <= 16'h0000;
      seq_r          <= 16'h0000;
      sync_r         <= 16'h0000;
      expectedSeq_r  <= 16'h0000;
      firstSeen_r    <= 1'b0;
      timer_r        <= 16'h0000;
      handlerIdx_r   <= {IdxW{1'b0}};
      rxHold_r       <= 1'b0;
      handlerStart_r <= {NUM_HANDLERS{1'b0}};
      dataLength_r   <= 16'h0000;
      replyRequest_r <= 1'b0;
      replyCode_r    <= 2'd0;
      replyMsgId_r   <= 16'h0000;
      replySeq_r     <= 16'h0000;
      msgCount_r     <= 16'h0000;
      errorCount_r   <= 16'h0000;
      seqGap_r       <= 1'b0;
      overrun_r      <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      handlerStart_r <= {NUM_HANDLERS{1'b0}};
      replyRequest_r <= 1'b0;
      seqGap_r       <= 1'b0;

      // A completion arriving while busy is dropped, but remembered.
      if (MessageComplete && (state_r != IDLE)) begin
        overrun_r <= 1'b1;
      end

      case (state_r)
        IDLE: begin
          if (MessageComplete) begin
            msgId_r       <= MessageID;
            byteCount_r   <= ByteCount;
            seq_r         <= SequenceNumber;
            sync_r        <= SyncWord;
            rxHold_r      <= 1'b1;
            seqGap_r      <= firstSeen_r && (SequenceNumber != expectedSeq_r);
            expectedSeq_r <= SequenceNumber + 16'd1;
            firstSeen_r   <= 1'b1;
            state_r       <= CHECK;
          end
        end

        CHECK: begin
          if (checkFail_s) begin
            replyCode_r  <= checkCode_s;
            replyMsgId_r <= msgId_r;
            replySeq_r   <= seq_r;
            errorCount_r <= satInc(errorCount_r);
            state_r      <= REPLY;
          end else begin
            // Start pulse and length become visible during the DISPATCH cycle.
            handlerIdx_r   <= idOffset_s[IdxW-1:0];
            handlerStart_r <= oneHot(idOffset_s[IdxW-1:0]);
            dataLength_r   <= byteCount_r - HeaderBytes;
            state_r        <= DISPATCH;
          end
        end

        DISPATCH: begin
          timer_r <= 16'h0000;
          state_r <= WAITDONE;
        end

        WAITDONE: begin
          // Done is tested first so it wins over a coincident timeout.
          if (doneHit_s) begin
            replyCode_r  <= CODE_ACK;
            replyMsgId_r <= msgId_r;
            replySeq_r   <= seq_r;
            msgCount_r   <= satInc(msgCount_r);
            state_r      <= REPLY;
          end else if (timer_r == TimeoutLast) begin
            replyCode_r  <= CODE_TIMEOUT;
            replyMsgId_r <= msgId_r;
            replySeq_r   <= seq_r;
            errorCount_r <= satInc(errorCount_r);
            state_r      <= REPLY;
          end else begin
            timer_r <= timer_r + 16'd1;
          end
        end

        REPLY: begin
          if (!ReplyBusy) begin
            replyRequest_r <= 1'b1;
            rxHold_r       <= 1'b0;
            state_r        <= IDLE;
          end
        end

        default: begin
          rxHold_r <= 1'b0;
          state_r  <= IDLE;
        end
      endcase
    end
  end

  assign RxHold       = rxHold_r;
  assign HandlerStart = handlerStart_r;
  assign DataLength   = dataLength_r;
  assign ReplyRequest = replyRequest_r;
  assign ReplyCode    = replyCode_r;
  assign ReplyMsgID   = replyMsgId_r;
  assign ReplySeq     = replySeq_r;
  assign MsgCount     = msgCount_r;
  assign ErrorCount   = errorCount_r;
  assign SeqGap       = seqGap_r;
  assign Overrun      = overrun_r;

endmodule

// File: tb/tb_msg_dispatch_controller.sv
// tb_msg_dispatch_controller
// Drives directed and random messages into msg_dispatch_controller and checks
// each one against a transaction-level model of the expected outcome: reply
// code, timing of HandlerStart/ReplyRequest, counters, SeqGap and Overrun.
module tb_msg_dispatch_controller;

  localparam logic [15:0] SYNC = 16'h1234;
  localparam logic [15:0] BASE = 16'h0100;

  logic        Clock = 1'b0;
  logic        Clear;
  logic [15:0] SyncWord;
  logic [15:0] MessageID;
  logic [15:0] ByteCount;
  logic [15:0] SequenceNumber;
  logic        MessageComplete;
  logic        RxHold;
  logic [3:0]  HandlerStart;
  logic [3:0]  HandlerDone;
  logic [15:0] DataLength;
  logic        ReplyRequest;
  logic [1:0]  ReplyCode;
  logic [15:0] ReplyMsgID;
  logic [15:0] ReplySeq;
  logic        ReplyBusy;
  logic [15:0] MsgCount;
  logic [15:0] ErrorCount;
  logic        SeqGap;
  logic        Overrun;

  int vecCount  = 0;
  int missCount = 0;

  // Reference model state
  logic [15:0] mMsgCount;
  logic [15:0] mErrCount;
  logic [15:0] mExpSeq;
  logic        mFirstSeen;
  logic        mOverrun;

  msg_dispatch_controller #(
    .NUM_HANDLERS(4),
    .ID_BASE(16'h0100),
    .SYNC_WORD(16'h1234),
    .MAX_BYTES(16'd64),
    .TIMEOUT(16'd1000)
  ) dut (
    .Clock(Clock),
    .Clear(Clear),
    .SyncWord(SyncWord),
    .MessageID(MessageID),
    .ByteCount(ByteCount),
    .SequenceNumber(SequenceNumber),
    .MessageComplete(MessageComplete),
    .RxHold(RxHold),
    .HandlerStart(HandlerStart),
    .HandlerDone(HandlerDone),
    .DataLength(DataLength),
    .ReplyRequest(ReplyRequest),
    .ReplyCode(ReplyCode),
    .ReplyMsgID(ReplyMsgID),
    .ReplySeq(ReplySeq),
    .ReplyBusy(ReplyBusy),
    .MsgCount(MsgCount),
    .ErrorCount(ErrorCount),
    .SeqGap(SeqGap),
    .Overrun(Overrun)
  );

  always #5 Clock = ~Clock;

  task automatic checkValue(input string tag, input logic [127:0] observed, input logic [127:0] expected);
    vecCount++;
    if (observed !== expected) begin
      missCount++;
      $display("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One message. doneD: cycles after HandlerStart that the handler's done bit
  // rises (1..1000 beats the timeout). busyUntil: ReplyBusy held for cycles
  // before this index. ovrK: cycle index of an extra MessageComplete (0 = none).
  task automatic runMsg(input logic [15:0] sync, input logic [15:0] id, input logic [15:0] bc,
                        input logic [15:0] seq, input int doneD, input int busyUntil, input int ovrK);
    logic [15:0] off;
    logic [1:0]  expCode;
    bit          disp;
    logic [3:0]  idxMask;
    int          doneK, reqK, ovr;
    bit          expGap;
    int          hsK, hsCount, rrK, rrCount, sgK, sgCount;
    logic [3:0]  hsVal;
    logic [15:0] dlObs, idObs, seqObs, mcObs, ecObs;
    logic [1:0]  codeObs;
    logic        rx1, rxPre, rxReq;

    off     = id - BASE;
    disp    = 1'b0;
    idxMask = 4'b0000;
    if (sync != SYNC) expCode = 2'd3;
    else if ((bc < 16'd8) || (bc > 16'd64)) expCode = 2'd1;
    else if (off >= 16'd4) expCode = 2'd2;
    else begin
      disp    = 1'b1;
      idxMask = 4'b0001 << off[1:0];
      expCode = ((doneD >= 1) && (doneD <= 1000)) ? 2'd0 : 2'd3;
    end
    // Cycle indices count rising edges after the one that captures the message.
    doneK = 2 + doneD;
    if (!disp) reqK = 3;
    else if (expCode == 2'd0) reqK = doneK + 2;
    else reqK = 1004;
    if (busyUntil + 1 > reqK) reqK = busyUntil + 1;
    ovr    = (ovrK < reqK) ? ovrK : 0;
    expGap = mFirstSeen && (seq != mExpSeq);

    if (expCode == 2'd0) mMsgCount = (mMsgCount == 16'hFFFF) ? mMsgCount : mMsgCount + 16'd1;
    else mErrCount = (mErrCount == 16'hFFFF) ? mErrCount : mErrCount + 16'd1;
    mExpSeq    = seq + 16'd1;
    mFirstSeen = 1'b1;
    if (ovr > 0) mOverrun = 1'b1;

    hsK = 0; hsCount = 0; rrK = 0; rrCount = 0; sgK = 0; sgCount = 0;
    hsVal = 4'b0000; dlObs = 16'h0000; idObs = 16'h0000; seqObs = 16'h0000;
    mcObs = 16'h0000; ecObs = 16'h0000; codeObs = 2'd0;
    rx1 = 1'b0; rxPre = 1'b0; rxReq = 1'b1;

    SyncWord = sync; MessageID = id; ByteCount = bc; SequenceNumber = seq;
    MessageComplete = 1'b1;
    ReplyBusy = (busyUntil > 0);
    for (int k = 1; k <= reqK + 3; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      if (HandlerStart != 4'b0000) begin
        hsCount++;
        if (hsK == 0) begin hsK = k; hsVal = HandlerStart; dlObs = DataLength; end
      end
      if (ReplyRequest) begin
        rrCount++;
        if (rrK == 0) begin
          rrK = k; codeObs = ReplyCode; idObs = ReplyMsgID; seqObs = ReplySeq;
          mcObs = MsgCount; ecObs = ErrorCount; rxReq = RxHold;
        end
      end
      if (SeqGap) begin sgCount++; sgK = k; end
      if (k == 1) rx1 = RxHold;
      if (k == reqK - 1) rxPre = RxHold;
      // Inputs for the next edge: noise on the other done bits, busy window, stray completion.
      HandlerDone = 4'($urandom) & ~idxMask;
      if (disp && (k >= doneK) && (rrCount == 0)) HandlerDone = HandlerDone | idxMask;
      ReplyBusy = (k < busyUntil);
      MessageComplete = (k == ovr);
      if (k == ovr) begin
        SyncWord = 16'($urandom); MessageID = 16'($urandom);
        ByteCount = 16'($urandom); SequenceNumber = 16'($urandom);
      end
    end
    MessageComplete = 1'b0; HandlerDone = 4'b0000; ReplyBusy = 1'b0;

    checkValue("start_time", 128'(hsK), 128'(disp ? 2 : 0));
    checkValue("start_val", 128'(hsVal), 128'(idxMask));
    checkValue("start_cnt", 128'(hsCount), 128'(disp ? 1 : 0));
    if (disp) checkValue("data_len", 128'(dlObs), 128'(bc - 16'd8));
    checkValue("req_time", 128'(rrK), 128'(reqK));
    checkValue("req_cnt", 128'(rrCount), 128'd1);
    checkValue("reply_code", 128'(codeObs), 128'(expCode));
    checkValue("reply_id", 128'(idObs), 128'(id));
    checkValue("reply_seq", 128'(seqObs), 128'(seq));
    checkValue("msg_count", 128'(mcObs), 128'(mMsgCount));
    checkValue("err_count", 128'(ecObs), 128'(mErrCount));
    checkValue("seq_gap_cnt", 128'(sgCount), 128'(expGap ? 1 : 0));
    if (expGap) checkValue("seq_gap_time", 128'(sgK), 128'd1);
    checkValue("rxhold_first", 128'(rx1), 128'd1);
    checkValue("rxhold_pre", 128'(rxPre), 128'd1);
    checkValue("rxhold_req", 128'(rxReq), 128'd0);
    checkValue("overrun", 128'(Overrun), 128'(mOverrun));
  endtask

  // Start a valid message for handler 0, then assert Clear clearK cycles in.
  task automatic runClear(input int clearK);
    SyncWord = SYNC; MessageID = BASE; ByteCount = 16'd20;
    SequenceNumber = 16'($urandom); MessageComplete = 1'b1;
    HandlerDone = 4'b0000; ReplyBusy = 1'b0;
    for (int k = 1; k <= clearK; k++) begin
      @(posedge Clock);
      @(negedge Clock);
      MessageComplete = 1'b0;
      if (k == 2) checkValue("clr_start", 128'(HandlerStart), 128'(4'b0001));
      if (k == clearK) checkValue("clr_rxhold_pre", 128'(RxHold), 128'd1);
    end
    Clear = 1'b1;
    #1;
    checkValue("clr_outs", 128'({HandlerStart, DataLength, ReplyRequest, ReplyCode, ReplyMsgID,
                                 ReplySeq, MsgCount, ErrorCount, SeqGap, Overrun}), 128'd0);
    checkValue("clr_rxhold", 128'(RxHold), 128'd0);
    @(negedge Clock);
    Clear = 1'b0;
    mMsgCount = 16'h0000; mErrCount = 16'h0000; mExpSeq = 16'h0000;
    mFirstSeen = 1'b0; mOverrun = 1'b0;
    @(negedge Clock);
  endtask

  initial begin
    logic [15:0] rSync, rId, rBc, rSeq;
    int          rDone, rBusy, rOvr;

    Clear = 1'b1;
    SyncWord = 16'h0000; MessageID = 16'h0000; ByteCount = 16'h0000;
    SequenceNumber = 16'h0000; MessageComplete = 1'b0;
    HandlerDone = 4'b0000; ReplyBusy = 1'b0;
    mMsgCount = 16'h0000; mErrCount = 16'h0000; mExpSeq = 16'h0000;
    mFirstSeen = 1'b0; mOverrun = 1'b0;

    repeat (3) @(negedge Clock);
    checkValue("reset_outs", 128'({RxHold, HandlerStart, DataLength, ReplyRequest, ReplyCode, ReplyMsgID,
                                   ReplySeq, MsgCount, ErrorCount, SeqGap, Overrun}), 128'd0);
    Clear = 1'b0;
    @(negedge Clock);

    // Basic dispatch to handler 1
    runMsg(SYNC, 16'h0101, 16'd12, 16'd5, 3, 0, 0);
    // Validation failures, priority and length boundaries
    runMsg(SYNC, 16'h0200, 16'd12, 16'd6, 3, 0, 0);
    runMsg(SYNC, 16'h0101, 16'd100, 16'd7, 3, 0, 0);
    runMsg(SYNC, 16'h0102, 16'd8, 16'd8, 2, 0, 0);
    runMsg(SYNC, 16'h00FF, 16'd20, 16'd9, 2, 0, 0);
    runMsg(16'h1235, 16'h0100, 16'd20, 16'd10, 2, 0, 0);
    runMsg(SYNC, 16'h0103, 16'd7, 16'd11, 2, 0, 0);
    runMsg(SYNC, 16'h0103, 16'd64, 16'd12, 1, 0, 0);
    runMsg(SYNC, 16'h0100, 16'd65, 16'd13, 1, 0, 0);
    runMsg(16'h0000, 16'h0200, 16'd200, 16'd14, 1, 0, 0);
    runMsg(SYNC, 16'h0300, 16'd3, 16'd15, 1, 0, 0);
    // Timeout, then done on the final allowed cycle
    runMsg(SYNC, 16'h0100, 16'd16, 16'd16, 1001, 0, 0);
    runMsg(SYNC, 16'h0103, 16'd16, 16'd17, 1000, 0, 0);
    // Sequence wrap and gap
    runMsg(SYNC, 16'h0101, 16'd9, 16'hFFFF, 2, 0, 0);
    runMsg(SYNC, 16'h0101, 16'd9, 16'h0000, 2, 0, 0);
    runMsg(SYNC, 16'h0101, 16'd9, 16'h0002, 2, 0, 0);
    // Transmitter busy for a long stretch, stray completion meanwhile
    runMsg(SYNC, 16'h0101, 16'd10, 16'h0003, 2, 30, 5);
    // Clear mid-wait and mid-dispatch; the next message is first after reset
    runClear(40);
    runMsg(SYNC, 16'h0102, 16'd24, 16'($urandom), 4, 0, 0);
    runClear(2);
    runMsg(SYNC, 16'h0100, 16'd30, 16'($urandom), 1, 3, 0);

    for (int n = 0; n < 40; n++) begin
      rSync = ($urandom_range(0, 9) == 0) ? 16'($urandom) : SYNC;
      case ($urandom_range(0, 3))
        0:       rBc = 16'($urandom_range(0, 7));
        1:       rBc = 16'($urandom_range(65, 300));
        default: rBc = 16'($urandom_range(8, 64));
      endcase
      rId   = ($urandom_range(0, 3) == 0) ? 16'($urandom) : BASE + 16'($urandom_range(0, 4));
      rSeq  = ($urandom_range(0, 2) == 0) ? 16'($urandom) : mExpSeq;
      rDone = ($urandom_range(0, 19) == 0) ? 1001 : int'($urandom_range(1, 12));
      rBusy = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 30)) : 0;
      rOvr  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 2)) : 0;
      runMsg(rSync, rId, rBc, rSeq, rDone, rBusy, rOvr);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
